bus_master_port: RTL and testbench
==================================

# bus_master_port

Single-master bus port between the CPU memory stage and the shared tristate system bus that the memory/IO slaves sit on. It turns one CPU load/store into one bus transaction: it registers the CPU request, drives request/address/r_w/data, waits for a slave's one-cycle ready, captures read data and releases the CPU stall. An optional timeout turns an unanswered request into a bus error, for example an address that no slave decodes.

## Interface
- TIMEOUT, 16: maximum BUSY cycles without ready before a bus error; minimum 8.
- HOLDOFF, 4: cycles after reset release during which no new transaction is launched; lets un-reset slaves drain.
- clk  input  1  bus clock; all state on posedge.
- clrn  input  1  asynchronous, active-low reset.
- cpu_req  input  1  CPU memory access request; held until the CPU sees stall low.
- cpu_we  input  1  1 = write, 0 = read.
- cpu_addr  input  32  byte/word address, passed through unchanged.
- cpu_wdata  input  32  write data.
- cpu_rdata  output  32  registered read data.
- cpu_stall  output  1  freezes the CPU pipeline.
- cpu_err  output  1  one-cycle bus-error pulse.
- bus_request  output  1  bus request line.
- bus_addr  output  32  bus address.
- bus_rw  output  1  1 = write, matching the slave convention.
- bus_data  inout  32  tristate data bus.
- bus_ready  input  1  slave ready. Top level provides a tri0 pulldown, so any non-1 value counts as 0.

## Operation
- States: HOLD, IDLE, BUSY, DONE, ERR.
- HOLD
  - Entered on reset.
  - Counts HOLDOFF cycles, then goes to IDLE.
  - cpu_stall = cpu_req.
- IDLE
  - cpu_stall = cpu_req.
  - On posedge with cpu_req=1: latch cpu_addr, cpu_we and cpu_wdata into addr_q, we_q and wdata_q, then go to BUSY.
- BUSY
  - bus_request=1, bus_addr=addr_q, bus_rw=we_q, cpu_stall=1.
  - Write: bus_data = wdata_q for every BUSY cycle.
  - Read: bus_data is released (Z).
  - On posedge with bus_ready=1: go to DONE; for a read, cpu_rdata <= bus_data.
- DONE
  - One cycle; bus_request=0, cpu_stall=0.
  - The CPU advances on the closing edge.
  - Always returns to IDLE; a cpu_req seen here belongs to the completed access.
- ERR
  - One cycle; cpu_stall=0, cpu_err=1, cpu_rdata <= 0.
  - Returns to IDLE.
- Outside BUSY: bus_request=0, bus_addr=0, bus_rw=0, bus_data=Z.
- The port never holds bus_request high in the cycle after ready, so a slave cannot re-select on a completed request.
- cpu_rdata keeps its last value across writes and idle cycles.

## Timing
- Reset (clrn=0, asynchronous):
  - State = HOLD, hold counter = 0, cpu_rdata=0, cpu_err=0.
  - bus_request, bus_addr and bus_rw are 0; bus_data is Z.
  - cpu_stall follows cpu_req.
- Reset mid-BUSY: the bus is released in the same cycle clrn falls. The aborted access is never acknowledged to the CPU.
- Read or write against a slave with a 4-cycle service time, cpu_req first seen in cycle 0:
  - bus_request high cycles 1–5.
  - Ready high in cycle 5.
  - DONE in cycle 6.
  - cpu_stall high cycles 0–5; 6 stall cycles total.
- Minimum gap between launches is 2 cycles (DONE, then IDLE); there is no back-to-back issue.
- Timeout counter: log2(TIMEOUT)+1 bits, cleared on IDLE→BUSY, incremented each BUSY cycle.
- If the counter equals TIMEOUT−1 and bus_ready=0: go to ERR. Ready wins when both occur on the same edge.

## Configuration
- BUS_TIMEOUT_EN defined: timeout counter and ERR state are present, as above.
- BUS_TIMEOUT_EN not defined:
  - Counter and ERR state are removed; cpu_err is tied to 0.
  - BUSY waits for ready indefinitely.

## Structure
- bus_pkg holds:
  - the state encoding (3-bit localparams HOLD, IDLE, BUSY, DONE, ERR);
  - the bus width constants (ADDR_W=32, DATA_W=32);
  - the bus_rw encoding (WRITE=1).
- One sub-module, bus_timeout_counter:
  - Inputs: clk, clrn, clear, enable.
  - Output: expired.
  - Parameterised by TIMEOUT.
  - Reused for the HOLD countdown with HOLDOFF.

## Test plan
- Write 0xDEADBEEF to 0x10 on a 4-cycle slave → bus_request high cycles 1–5, bus_rw=1, bus_data=0xDEADBEEF during BUSY, stall drops in cycle 6, cpu_err=0.
- Read 0x10 after that write → bus_data Z from the port during BUSY; cpu_rdata=0xDEADBEEF from cycle 6; request low in cycle 6.
- Read 0x1000, which no slave decodes, with TIMEOUT=16 → bus_request high for 16 cycles, one ERR cycle with cpu_err=1 and cpu_rdata=0, then IDLE. Built without BUS_TIMEOUT_EN → stall stays high.
- Back-to-back: read 0x20 held, then a write to 0x21 presented in the DONE cycle → second bus_request rises 2 cycles after the first DONE; both complete.
- clrn pulsed low in the third BUSY cycle of a read → request and bus_data released asynchronously; no request for HOLDOFF=4 cycles after release; a queued cpu_req then starts normally.
- Ready on the same edge that the timeout expires (slave delayed to TIMEOUT cycles) → DONE taken, cpu_err=0, data captured.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared encodings for the CPU-to-system-bus master port.
package bus_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef logic [2:0] state_t;

    localparam state_t HOLD = 3'd0;
    localparam state_t IDLE = 3'd1;
    localparam state_t BUSY = 3'd2;
    localparam state_t DONE = 3'd3;
    localparam state_t ERR  = 3'd4;

    localparam logic WRITE = 1'b1;

    // The bus line is pulled down; anything that is not a clean 1 means not ready.
    function automatic logic is_ready(input logic r);
        return r === 1'b1;
    endfunction

endpackage

// File: rtl/bus_timeout_counter.sv
// Saturating up-counter that flags when TIMEOUT cycles have been counted.
// Used both for the post-reset holdoff and for the bus timeout.
module bus_timeout_counter #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic clrn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expired) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == LAST);

endmodule

// File: rtl/bus_master_port.sv
// Single-master port: one CPU load/store becomes one tristate bus transaction.
// Define BUS_TIMEOUT_EN to turn an unanswered request into a cpu_err pulse.
module bus_master_port
    import bus_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int HOLDOFF = 4
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    output logic              cpu_err,
    output logic              bus_request,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_rw,
    inout  wire  [DATA_W-1:0] bus_data,
    input  logic              bus_ready
);

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;

    logic ready;
    logic busy;
    logic launch;
    logic hold_done;

    assign ready  = is_ready(bus_ready);
    assign busy   = (state_q == BUSY);
    assign launch = (state_q == IDLE) && cpu_req;

    bus_timeout_counter #(
        .TIMEOUT (HOLDOFF)
    ) u_hold (
        .clk     (clk),
        .clrn    (clrn),
        .clear   (state_q != HOLD),
        .enable  (state_q == HOLD),
        .expired (hold_done)
    );

`ifdef BUS_TIMEOUT_EN
    logic tmo_expired;

    bus_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .clk     (clk),
        .clrn    (clrn),
        .clear   (launch),
        .enable  (busy),
        .expired (tmo_expired)
    );
`endif

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= HOLD;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            unique case (state_q)
                HOLD: begin
                    if (hold_done) begin
                        state_q <= IDLE;
                    end
                end
                IDLE: begin
                    if (launch) begin
                        addr_q  <= cpu_addr;
                        we_q    <= cpu_we;
                        wdata_q <= cpu_wdata;
                        state_q <= BUSY;
                    end
                end
                // Ready is checked first so it wins over a same-edge timeout.
                BUSY: begin
                    if (ready) begin
                        state_q <= DONE;
                        if (we_q != WRITE) begin
                            rdata_q <= bus_data;
                        end
                    end
`ifdef BUS_TIMEOUT_EN
                    else if (tmo_expired) begin
                        state_q <= ERR;
                        rdata_q <= '0;
                    end
`endif
                end
                DONE: begin
                    state_q <= IDLE;
                end
`ifdef BUS_TIMEOUT_EN
                ERR: begin
                    state_q <= IDLE;
                end
`endif
                default: begin
                    state_q <= HOLD;
                end
            endcase
        end
    end

    always_comb begin
        cpu_stall = 1'b0;
        unique case (state_q)
            HOLD:    cpu_stall = cpu_req;
            IDLE:    cpu_stall = cpu_req;
            BUSY:    cpu_stall = 1'b1;
            default: cpu_stall = 1'b0;
        endcase
    end

    assign bus_request = busy;
    assign bus_addr    = busy ? addr_q : '0;
    assign bus_rw      = busy & (we_q == WRITE);
    assign bus_data    = (busy && we_q == WRITE) ? wdata_q : 'z;
    assign cpu_rdata   = rdata_q;

`ifdef BUS_TIMEOUT_EN
    assign cpu_err = (state_q == ERR);
`else
    assign cpu_err = 1'b0;
`endif

endmodule

// File: tb/tb_bus_master_port.sv
// Bench for bus_master_port: a latency-programmable slave plus a scoreboard of
// expected transaction timing and results.
module tb_bus_master_port;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        cpu_err;
    logic        bus_request;
    logic [31:0] bus_addr;
    logic        bus_rw;
    wire  [31:0] bus_data;
    logic        bus_ready;

    logic [31:0] mem [256];
    int          slave_lat = 0;
    int          slv_cnt = 0;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_rd = '0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        logic        err;
        int          first;
        int          nreq;
        int          done;
    } exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        int          lat;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[8];

    always #5 clk = ~clk;

    bus_master_port dut (
        .clk         (clk),
        .clrn        (clrn),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .cpu_stall   (cpu_stall),
        .cpu_err     (cpu_err),
        .bus_request (bus_request),
        .bus_addr    (bus_addr),
        .bus_rw      (bus_rw),
        .bus_data    (bus_data),
        .bus_ready   (bus_ready)
    );

    // Slave decodes 0x000-0x0FF and answers after slave_lat request cycles.
    // When the port should be released the slave drives zero, so any
    // contribution from the port shows up as a nonzero bus value.
    assign bus_ready = bus_request && (bus_addr < 32'h100) &&
                       (slv_cnt == slave_lat);
    assign bus_data  = (bus_request && bus_rw) ? 'z :
                       ((bus_request && bus_ready) ? mem[bus_addr[7:0]] : '0);

    always @(posedge clk) begin
        slv_cnt <= bus_request ? slv_cnt + 1 : 0;
        if (bus_ready && bus_rw) begin
            mem[bus_addr[7:0]] <= bus_data;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    task automatic push(input logic we, input logic [31:0] a,
                        input logic [31:0] w, input logic [31:0] rd,
                        input logic err, input int first, input int nreq,
                        input int done);
        exp_t e;
        e.we = we; e.addr = a; e.wdata = w; e.rd = rd;
        e.err = err; e.first = first; e.nreq = nreq; e.done = done;
        exp_q.push_back(e);
    endtask

    // Cycle 0 is the first negedge after the call.
    task automatic monitor();
        exp_t e;
        int   nreq;
        int   first;
        bit   fin;
        nreq  = 0;
        first = -1;
        fin   = 0;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: got empty queue expected entry");
            return;
        end
        e = exp_q.pop_front();
        for (int cyc = 0; cyc < 80 && !fin; cyc++) begin
            @(negedge clk);
            if (bus_request) begin
                if (first < 0) first = cyc;
                nreq++;
                chk("bus_addr", bus_addr, e.addr);
                chk("bus_rw", bus_rw, e.we);
                if (e.we) chk("bus_wdata", bus_data, e.wdata);
                else if (!bus_ready) chk("bus_rd_release", bus_data, 0);
            end else begin
                chk("idle_addr", bus_addr, 0);
                chk("idle_rw", bus_rw, 0);
                chk("idle_release", bus_data, 0);
            end
            if (!cpu_stall) begin
                fin = 1;
                chk("done_cycle", cyc, e.done);
                chk("first_req", first, e.first);
                chk("req_cycles", nreq, e.nreq);
                chk("cpu_err", cpu_err, e.err);
                chk("cpu_rdata", cpu_rdata, e.rd);
                last_rd = e.rd;
            end else begin
                chk("err_early", cpu_err, 0);
            end
        end
        if (!fin) begin
            checks++;
            errors++;
            $display("FAIL stall_bound: got stall high expected release");
        end
    endtask

    task automatic start(input logic we, input logic [31:0] a,
                         input logic [31:0] w, input int lat);
        @(posedge clk);
        #1;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = w;
        slave_lat = lat;
    endtask

    task automatic finish_access();
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        @(negedge clk);
        chk("err_pulse", cpu_err, 0);
        chk("idle_stall", cpu_stall, 0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 32'h0,        4};
        vecs[1] = '{1'b0, 32'h10, 32'h5555AAAA, 32'hDEADBEEF, 4};
        vecs[2] = '{1'b1, 32'h24, 32'hA5A50F0F, 32'h0,        0};
        vecs[3] = '{1'b0, 32'h24, 32'hFFFFFFFF, 32'hA5A50F0F, 2};
        vecs[4] = '{1'b0, 32'h10, 32'hFFFFFFFF, 32'hDEADBEEF, 15};
        vecs[5] = '{1'b1, 32'h20, 32'hCAFEF00D, 32'h0,        7};
        vecs[6] = '{1'b0, 32'h20, 32'hFFFFFFFF, 32'hCAFEF00D, 1};
        vecs[7] = '{1'b1, 32'h30, 32'h01234567, 32'h0,        3};

        #3;
        chk("rst_rdata", cpu_rdata, 0);
        chk("rst_err", cpu_err, 0);
        chk("rst_req", bus_request, 0);
        chk("rst_addr", bus_addr, 0);
        chk("rst_rw", bus_rw, 0);
        chk("rst_release", bus_data, 0);
        chk("rst_stall0", cpu_stall, 0);
        cpu_req = 1'b1;
        #1;
        chk("rst_stall1", cpu_stall, 1);
        cpu_req = 1'b0;
        @(negedge clk);
        clrn = 1'b1;
        repeat (6) @(posedge clk);

        for (int i = 0; i < 8; i++) begin
            start(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].lat);
            push(vecs[i].we, vecs[i].addr, vecs[i].wdata,
                 vecs[i].we ? last_rd : vecs[i].rd, 1'b0,
                 1, vecs[i].lat + 1, vecs[i].lat + 2);
            monitor();
            finish_access();
        end

        // Read held through DONE, write presented in the DONE cycle.
        start(1'b0, 32'h20, 32'hFFFFFFFF, 2);
        push(1'b0, 32'h20, 32'hFFFFFFFF, 32'hCAFEF00D, 1'b0, 1, 3, 4);
        monitor();
        cpu_we    = 1'b1;
        cpu_addr  = 32'h21;
        cpu_wdata = 32'h13579BDF;
        slave_lat = 1;
        push(1'b1, 32'h21, 32'h13579BDF, 32'hCAFEF00D, 1'b0, 1, 2, 3);
        monitor();
        finish_access();

        start(1'b0, 32'h21, 32'h0, 0);
        push(1'b0, 32'h21, 32'h0, 32'h13579BDF, 1'b0, 1, 1, 2);
        monitor();
        finish_access();

        // Undecoded address.
`ifdef BUS_TIMEOUT_EN
        start(1'b0, 32'h1000, 32'hFFFFFFFF, 0);
        push(1'b0, 32'h1000, 32'hFFFFFFFF, 32'h0, 1'b1, 1, 16, 17);
        monitor();
        finish_access();
`else
        start(1'b0, 32'h1000, 32'hFFFFFFFF, 0);
        repeat (40) begin
            @(negedge clk);
            chk("hang_stall", cpu_stall, 1);
        end
        chk("hang_req", bus_request, 1);
        clrn = 1'b0;
        #1;
        chk("hang_rst_req", bus_request, 0);
        cpu_req = 1'b0;
        @(negedge clk);
        clrn    = 1'b1;
        last_rd = '0;
        repeat (6) @(posedge clk);
`endif

        // Reset in the third BUSY cycle of a read; cpu_req stays queued.
        start(1'b0, 32'h10, 32'h0, 3);
        repeat (4) @(negedge clk);
        chk("pre_rst_req", bus_request, 1);
        clrn = 1'b0;
        #1;
        chk("mid_rst_req", bus_request, 0);
        chk("mid_rst_addr", bus_addr, 0);
        chk("mid_rst_release", bus_data, 0);
        chk("mid_rst_stall", cpu_stall, 1);
        chk("mid_rst_rdata", cpu_rdata, 0);
        @(negedge clk);
        clrn    = 1'b1;
        last_rd = '0;
        push(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 4, 4, 8);
        monitor();
        finish_access();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

endmodule
